// File: rtl/stopwatch_pkg.sv
// +----------------------------------------------------------------------------
// | Module      : stopwatch_pkg
// | Description : Shared state encodings, default limits and field widths.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  localparam int CS_W  = 7;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;

  localparam int CS_MAX_DEF  = 99;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_STOP = 2'd2;
  localparam state_t ST_LAP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/stopwatch_time_counter.sv
// +----------------------------------------------------------------------------
// | Module      : stopwatch_time_counter
// | Description : Cascaded centisecond/second/minute counter with wrap pulse.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CS_MAX  = CS_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CS_W-1:0]  cs,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic             wrap
);

  localparam logic [CS_W-1:0]  c_cs_max  = CS_W'(CS_MAX);
  localparam logic [SEC_W-1:0] c_sec_max = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] c_min_max = MIN_W'(MIN_MAX);

  logic [CS_W-1:0]  r_cs;
  logic [SEC_W-1:0] r_sec;
  logic [MIN_W-1:0] r_min;
  logic             r_wrap;

  logic w_cs_top;
  logic w_sec_top;
  logic w_min_top;

  assign w_cs_top  = (r_cs  == c_cs_max);
  assign w_sec_top = (r_sec == c_sec_max);
  assign w_min_top = (r_min == c_min_max);

  // Clear shares the reset path so it beats a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cs   <= '0;
      r_sec  <= '0;
      r_min  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (inc) begin
        if (w_cs_top) begin
          r_cs <= '0;
          if (w_sec_top) begin
            r_sec <= '0;
            if (w_min_top) begin
              r_min  <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_min <= r_min + MIN_W'(1);
            end
          end else begin
            r_sec <= r_sec + SEC_W'(1);
          end
        end else begin
          r_cs <= r_cs + CS_W'(1);
        end
      end
    end
  end

  assign cs   = r_cs;
  assign sec  = r_sec;
  assign min  = r_min;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// +----------------------------------------------------------------------------
// | Module      : stopwatch_ctrl
// | Description : Button edge detect, run/stop/lap/clear FSM, lap hold, display mux.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CS_MAX  = CS_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_ss,
  input  logic             btn_lc,
  output logic [CS_W-1:0]  disp_cs,
  output logic [SEC_W-1:0] disp_sec,
  output logic [MIN_W-1:0] disp_min,
  output logic             running,
  output logic             lap_active,
  output logic             overflow,
  output logic [1:0]       state
);

  logic   r_ss_prev;
  logic   r_lc_prev;
  state_t r_state;
  state_t w_next_state;

  logic [CS_W-1:0]  r_lap_cs;
  logic [SEC_W-1:0] r_lap_sec;
  logic [MIN_W-1:0] r_lap_min;

  logic [CS_W-1:0]  w_cnt_cs;
  logic [SEC_W-1:0] w_cnt_sec;
  logic [MIN_W-1:0] w_cnt_min;
  logic             w_cnt_wrap;

  logic w_ss_edge;
  logic w_lc_edge;
  logic w_inc;
  logic w_clear;
  logic w_lap_load;

  // History resets high so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_prev <= 1'b1;
      r_lc_prev <= 1'b1;
    end else begin
      r_ss_prev <= btn_ss;
      r_lc_prev <= btn_lc;
    end
  end

  assign w_ss_edge  = btn_ss & ~r_ss_prev;
  assign w_lc_edge  = btn_lc & ~r_lc_prev & ~w_ss_edge;
  assign w_inc      = tick & ((r_state == ST_RUN) || (r_state == ST_LAP));
  assign w_clear    = (r_state == ST_STOP) & w_lc_edge;
  assign w_lap_load = (r_state == ST_RUN) & w_lc_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_ss_edge) w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_ss_edge)      w_next_state = ST_STOP;
        else if (w_lc_edge) w_next_state = ST_LAP;
      end
      ST_LAP: begin
        if (w_ss_edge)      w_next_state = ST_STOP;
        else if (w_lc_edge) w_next_state = ST_RUN;
      end
      ST_STOP: begin
        if (w_ss_edge)      w_next_state = ST_RUN;
        else if (w_lc_edge) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Lap capture takes the live value before this cycle's increment lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lap_cs  <= '0;
      r_lap_sec <= '0;
      r_lap_min <= '0;
    end else if (w_lap_load) begin
      r_lap_cs  <= w_cnt_cs;
      r_lap_sec <= w_cnt_sec;
      r_lap_min <= w_cnt_min;
    end
  end

  stopwatch_time_counter #(
    .CS_MAX  (CS_MAX),
    .SEC_MAX (SEC_MAX),
    .MIN_MAX (MIN_MAX)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .inc   (w_inc),
    .cs    (w_cnt_cs),
    .sec   (w_cnt_sec),
    .min   (w_cnt_min),
    .wrap  (w_cnt_wrap)
  );

  always_comb begin
    state      = r_state;
    running    = (r_state == ST_RUN) || (r_state == ST_LAP);
    lap_active = (r_state == ST_LAP);
    overflow   = w_cnt_wrap;
    if (r_state == ST_LAP) begin
      disp_cs  = r_lap_cs;
      disp_sec = r_lap_sec;
      disp_min = r_lap_min;
    end else begin
      disp_cs  = w_cnt_cs;
      disp_sec = w_cnt_sec;
      disp_min = w_cnt_min;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// +----------------------------------------------------------------------------
// | Module      : tb_stopwatch_ctrl
// | Description : Scoreboard bench for stopwatch_ctrl, full-size and small-limit instances.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

    typedef struct packed {
        logic       sel;
        logic [6:0] cs;
        logic [5:0] sec;
        logic [5:0] min;
        logic [1:0] st;
        logic       run;
        logic       lap;
        logic       ovf;
    } exp_t;

    logic clk;
    logic reset;
    logic tick, btn_ss, btn_lc;
    logic tick_s, btn_ss_s, btn_lc_s;

    logic [6:0] m_cs, s_cs;
    logic [5:0] m_sec, m_min, s_sec, s_min;
    logic       m_run, m_lap, m_ovf, s_run, s_lap, s_ovf;
    logic [1:0] m_st, s_st;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  e, act;
    string nm;
    int    n_cmp = 0;
    int    n_err = 0;

    stopwatch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn_ss     (btn_ss),
        .btn_lc     (btn_lc),
        .disp_cs    (m_cs),
        .disp_sec   (m_sec),
        .disp_min   (m_min),
        .running    (m_run),
        .lap_active (m_lap),
        .overflow   (m_ovf),
        .state      (m_st)
    );

    stopwatch_ctrl #(.CS_MAX(3), .SEC_MAX(2), .MIN_MAX(1)) dut_s (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick_s),
        .btn_ss     (btn_ss_s),
        .btn_lc     (btn_lc_s),
        .disp_cs    (s_cs),
        .disp_sec   (s_sec),
        .disp_min   (s_min),
        .running    (s_run),
        .lap_active (s_lap),
        .overflow   (s_ovf),
        .state      (s_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every queued expectation is compared on the next falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.sel) act = {1'b1, s_cs, s_sec, s_min, s_st, s_run, s_lap, s_ovf};
            else       act = {1'b0, m_cs, m_sec, m_min, m_st, m_run, m_lap, m_ovf};
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %0d:%0d.%0d st=%0d run=%0d lap=%0d ovf=%0d, expected %0d:%0d.%0d st=%0d run=%0d lap=%0d ovf=%0d",
                         nm, act.min, act.sec, act.cs, act.st, act.run, act.lap, act.ovf,
                         e.min, e.sec, e.cs, e.st, e.run, e.lap, e.ovf);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input logic sel, input int mn, input int sc, input int c,
                            input int st, input logic run, input logic lap,
                            input logic ovf, input string name);
        exp_t x;
        x.sel = sel;
        x.cs  = 7'(c);
        x.sec = 6'(sc);
        x.min = 6'(mn);
        x.st  = 2'(st);
        x.run = run;
        x.lap = lap;
        x.ovf = ovf;
        exp_q.push_back(x);
        name_q.push_back(name);
    endtask

    // Drive one main-instance button cycle; buttons and tick drop afterwards.
    task automatic press(input logic ss, input logic lc, input logic tk);
        btn_ss = ss;
        btn_lc = lc;
        tick   = tk;
        step();
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        tick   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (3) step();
        end
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0; btn_ss = 1'b0; btn_lc = 1'b0;
        tick_s = 1'b0; btn_ss_s = 1'b0; btn_lc_s = 1'b0;
        step();
        step();
        expect_o(0, 0, 0, 0, 0, 0, 0, 0, "reset_main");
        expect_o(1, 0, 0, 0, 0, 0, 0, 0, "reset_small");
        reset = 1'b0;
        step();

        press(1, 0, 0); expect_o(0, 0, 0, 0, 1, 1, 0, 0, "ss_start"); step();
        ticks(150);     expect_o(0, 0, 1, 50, 1, 1, 0, 0, "run_150");
        ticks(50);      expect_o(0, 0, 2, 0, 1, 1, 0, 0, "run_200");
        press(0, 1, 0); expect_o(0, 0, 2, 0, 3, 1, 1, 0, "lap_enter"); step();
        ticks(300);     expect_o(0, 0, 2, 0, 3, 1, 1, 0, "lap_frozen");
        press(0, 1, 0); expect_o(0, 0, 5, 0, 1, 1, 0, 0, "lap_release"); step();

        press(1, 0, 1); expect_o(0, 0, 5, 1, 2, 0, 0, 0, "stop_tick_counted"); step();
        ticks(50);      expect_o(0, 0, 5, 1, 2, 0, 0, 0, "stop_hold");
        press(1, 0, 1); expect_o(0, 0, 5, 1, 1, 1, 0, 0, "resume_tick_ignored"); step();
        press(1, 0, 0); expect_o(0, 0, 5, 1, 2, 0, 0, 0, "stop_again"); step();
        press(0, 1, 1); expect_o(0, 0, 0, 0, 0, 0, 0, 0, "clear"); step();
        press(0, 1, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, "idle_lc_ignored"); step();

        press(1, 0, 0); expect_o(0, 0, 0, 0, 1, 1, 0, 0, "restart"); step();
        ticks(37);      expect_o(0, 0, 0, 37, 1, 1, 0, 0, "run_37");
        press(1, 1, 0); expect_o(0, 0, 0, 37, 2, 0, 0, 0, "ss_lc_same_clk"); step();
        press(1, 0, 0); expect_o(0, 0, 0, 37, 1, 1, 0, 0, "resume2"); step();
        press(0, 1, 0); expect_o(0, 0, 0, 37, 3, 1, 1, 0, "lap_reload"); step();
        ticks(10);      expect_o(0, 0, 0, 37, 3, 1, 1, 0, "lap_frozen2");
        press(1, 0, 0); expect_o(0, 0, 0, 47, 2, 0, 0, 0, "lap_to_stop"); step();

        press(0, 1, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, "clear2"); step();
        press(1, 0, 0); expect_o(0, 0, 0, 0, 1, 1, 0, 0, "restart2"); step();
        ticks(1037);    expect_o(0, 0, 10, 37, 1, 1, 0, 0, "run_1037");
        btn_ss = 1'b1; tick = 1'b1; reset = 1'b1;
        step();
        tick = 1'b0;
        expect_o(0, 0, 0, 0, 0, 0, 0, 0, "reset_mid_run");
        reset = 1'b0;
        step(); step();
        expect_o(0, 0, 0, 0, 0, 0, 0, 0, "held_after_reset");
        btn_ss = 1'b0;
        step();
        expect_o(0, 0, 0, 0, 0, 0, 0, 0, "release_after_reset");
        btn_ss = 1'b1;
        step();
        expect_o(0, 0, 0, 0, 1, 1, 0, 0, "repress_after_reset");
        btn_ss = 1'b0;
        step();

        // Small-limit instance: wrap after 4*3*2 = 24 ticks.
        btn_ss_s = 1'b1;
        step();
        btn_ss_s = 1'b0;
        expect_o(1, 0, 0, 0, 1, 1, 0, 0, "small_start");
        step();
        for (int i = 0; i < 23; i++) begin
            tick_s = 1'b1;
            step();
        end
        tick_s = 1'b0;
        expect_o(1, 1, 2, 3, 1, 1, 0, 0, "small_pre_wrap");
        step();
        tick_s = 1'b1;
        step();
        tick_s = 1'b0;
        expect_o(1, 0, 0, 0, 1, 1, 0, 1, "small_wrap");
        step();
        expect_o(1, 0, 0, 0, 1, 1, 0, 0, "small_wrap_pulse_end");
        tick_s = 1'b1;
        step();
        tick_s = 1'b0;
        expect_o(1, 0, 0, 1, 1, 1, 0, 0, "small_after_wrap");
        step();
        step();

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending: %0d expectations never compared", exp_q.size());
        end
        if (n_cmp == 0) begin
            n_err++;
            $display("FAIL no_compares: monitor compared nothing");
        end
        if (n_err != 0) $display("FAIL: %0d errors", n_err);
        else            $display("PASS: all %0d comparisons matched", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
